// File: rtl/flash_pkg.sv
// Shared constants and types for the SPI-flash operation sequencer.
package flash_pkg;

  // Flash opcodes
  localparam logic [7:0] OpcWren = 8'h06;
  localparam logic [7:0] OpcRdsr = 8'h05;
  localparam logic [7:0] OpcSe   = 8'h20;
  localparam logic [7:0] OpcPp   = 8'h02;
  localparam logic [7:0] OpcRdid = 8'h90;
  localparam logic [7:0] OpcRead = 8'h03;

  // Transaction types understood by the spi byte engine (cmd_type[2:0])
  localparam logic [2:0] TxnRdid = 3'b000;
  localparam logic [2:0] TxnWren = 3'b001;
  localparam logic [2:0] TxnSe   = 3'b010;
  localparam logic [2:0] TxnRdsr = 3'b011;
  localparam logic [2:0] TxnPp   = 3'b101;
  localparam logic [2:0] TxnRead = 3'b111;

  // Number of bytes returned by each read op
  localparam logic [8:0] RdLenId   = 9'd2;
  localparam logic [8:0] RdLenPage = 9'd256;

  typedef enum logic [1:0] {
    OpReadId      = 2'b00,
    OpEraseSector = 2'b01,
    OpProgramByte = 2'b10,
    OpReadPage    = 2'b11
  } req_op_e;

  typedef enum logic [3:0] {
    StIdle,
    StWrenL,
    StWrenW,
    StOpL,
    StOpW,
    StPollL,
    StPollW,
    StGap,
    StDone
  } state_e;

  // Ops that modify the array need WREN first and WIP polling afterwards
  function automatic logic op_is_write(req_op_e op);
    return (op == OpEraseSector) || (op == OpProgramByte);
  endfunction

endpackage

// File: rtl/flash_txn_launcher.sv
// Issues one spi transaction: a single-cycle launch bit, then holds all fields until Done_Sig.
module flash_txn_launcher
  import flash_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [2:0]  i_type,
  input  logic [7:0]  i_opcode,
  input  logic [23:0] i_addr,
  input  logic [7:0]  i_data,
  input  logic        i_done_sig,
  output logic [3:0]  o_cmd_type,
  output logic [7:0]  o_flash_cmd,
  output logic [23:0] o_flash_addr,
  output logic [7:0]  o_wrdata,
  output logic        o_txn_done
);

  logic        r_launch;
  logic        r_busy;
  logic [2:0]  r_type;
  logic [7:0]  r_cmd;
  logic [23:0] r_addr;
  logic [7:0]  r_data;

  // Done_Sig only counts while a transaction is outstanding and past its launch cycle
  assign o_txn_done   = r_busy & ~r_launch & i_done_sig;
  assign o_cmd_type   = {r_launch, r_type};
  assign o_flash_cmd  = r_cmd;
  assign o_flash_addr = r_addr;
  assign o_wrdata     = r_data;

  // Launch pulse, field capture and outstanding-transaction flag
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_launch <= 1'b0;
      r_busy   <= 1'b0;
      r_type   <= 3'b000;
      r_cmd    <= 8'h00;
      r_addr   <= 24'h000000;
      r_data   <= 8'h00;
    end else begin
      r_launch <= i_start;
      if (i_start) begin
        r_busy <= 1'b1;
        r_type <= i_type;
        r_cmd  <= i_opcode;
        r_addr <= i_addr;
        r_data <= i_data;
      end else if (o_txn_done) begin
        r_busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/flash_op_sequencer.sv
// Sequences host flash ops into WREN / command / RDSR-poll spi transactions.
module flash_op_sequencer
  import flash_pkg::*;
#(
  parameter int unsigned POLL_GAP = 16,
  parameter int unsigned POLL_MAX = 65535
) (
  input  logic        clock25M,
  input  logic        flash_rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [23:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rd_valid,
  output logic [7:0]  rd_data,
  output logic        rd_last,
  output logic        resp_done,
  output logic        resp_err,
  output logic [3:0]  cmd_type,
  output logic [7:0]  flash_cmd,
  output logic [23:0] flash_addr,
  output logic [7:0]  wrdata,
  input  logic        Done_Sig,
  input  logic [7:0]  mydata_o,
  input  logic        myvalid_o
);

  localparam int unsigned PollW = $clog2(POLL_MAX + 1);
  // Gap counter only has to hold POLL_GAP-1
  localparam int unsigned GapW  = (POLL_GAP > 2) ? $clog2(POLL_GAP) : 1;

  state_e          r_state;
  state_e          w_state_next;
  req_op_e         r_op;
  logic [23:0]     r_addr;
  logic [7:0]      r_wdata;
  logic [PollW-1:0] r_poll_cnt;
  logic [GapW-1:0] r_gap_cnt;
  logic            r_wip;
  logic            r_err;
  logic [8:0]      r_rd_cnt;
  logic            r_rd_valid;
  logic            r_rd_last;
  logic [7:0]      r_rd_data;

  logic            w_accept;
  logic            w_txn_done;
  logic            w_start;
  logic [2:0]      w_type;
  logic [7:0]      w_opcode;
  logic [23:0]     w_txn_addr;
  logic [7:0]      w_txn_data;
  logic            w_wip_now;
  logic            w_poll_max;
  logic            w_gap_end;
  logic            w_rd_fwd;
  logic [8:0]      w_rd_limit;

  assign w_accept   = (r_state == StIdle) & req_valid;
  // A status byte arriving together with Done_Sig still decides the poll
  assign w_wip_now  = myvalid_o ? mydata_o[0] : r_wip;
  assign w_poll_max = (r_poll_cnt == PollW'(POLL_MAX));
  assign w_gap_end  = (r_gap_cnt == '0);
  assign w_rd_fwd   = (r_state == StOpW) & ~op_is_write(r_op) & myvalid_o;
  assign w_rd_limit = (r_op == OpReadId) ? RdLenId : RdLenPage;

  assign rd_valid = r_rd_valid;
  assign rd_data  = r_rd_data;
  assign rd_last  = r_rd_last;

  flash_txn_launcher u_launcher (
    .i_clk        (clock25M),
    .i_rst_n      (flash_rstn),
    .i_start      (w_start),
    .i_type       (w_type),
    .i_opcode     (w_opcode),
    .i_addr       (w_txn_addr),
    .i_data       (w_txn_data),
    .i_done_sig   (Done_Sig),
    .o_cmd_type   (cmd_type),
    .o_flash_cmd  (flash_cmd),
    .o_flash_addr (flash_addr),
    .o_wrdata     (wrdata),
    .o_txn_done   (w_txn_done)
  );

  // State register
  always_ff @(posedge clock25M or negedge flash_rstn) begin
    if (!flash_rstn) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (req_valid) begin
                 w_state_next = op_is_write(req_op_e'(req_op)) ? StWrenL : StOpL;
               end
      StWrenL: w_state_next = StWrenW;
      StWrenW: if (w_txn_done) w_state_next = StOpL;
      StOpL:   w_state_next = StOpW;
      StOpW:   if (w_txn_done) w_state_next = op_is_write(r_op) ? StPollL : StDone;
      StPollL: w_state_next = StPollW;
      StPollW: if (w_txn_done) w_state_next = (!w_wip_now || w_poll_max) ? StDone : StGap;
      StGap:   if (w_gap_end) w_state_next = StPollL;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Host handshake, response pulse and transaction selection per state
  always_comb begin
    req_ready  = 1'b0;
    resp_done  = 1'b0;
    resp_err   = 1'b0;
    w_start    = 1'b0;
    w_type     = TxnRdid;
    w_opcode   = 8'h00;
    w_txn_addr = 24'h000000;
    w_txn_data = 8'h00;
    unique case (r_state)
      StIdle:  req_ready = 1'b1;
      StWrenL: begin
        w_start  = 1'b1;
        w_type   = TxnWren;
        w_opcode = OpcWren;
      end
      StOpL: begin
        w_start = 1'b1;
        unique case (r_op)
          OpReadId: begin
            w_type   = TxnRdid;
            w_opcode = OpcRdid;
          end
          OpEraseSector: begin
            w_type     = TxnSe;
            w_opcode   = OpcSe;
            w_txn_addr = r_addr;
          end
          OpProgramByte: begin
            w_type     = TxnPp;
            w_opcode   = OpcPp;
            w_txn_addr = r_addr;
            w_txn_data = r_wdata;
          end
          OpReadPage: begin
            w_type     = TxnRead;
            w_opcode   = OpcRead;
            w_txn_addr = r_addr;
          end
          default: ;
        endcase
      end
      StPollL: begin
        w_start  = 1'b1;
        w_type   = TxnRdsr;
        w_opcode = OpcRdsr;
      end
      StDone: begin
        resp_done = 1'b1;
        resp_err  = r_err;
      end
      default: ;
    endcase
  end

  // Request capture, read forwarding, poll/gap counters and error flag
  always_ff @(posedge clock25M or negedge flash_rstn) begin
    if (!flash_rstn) begin
      r_op       <= OpReadId;
      r_addr     <= 24'h000000;
      r_wdata    <= 8'h00;
      r_poll_cnt <= '0;
      r_gap_cnt  <= '0;
      r_wip      <= 1'b0;
      r_err      <= 1'b0;
      r_rd_cnt   <= 9'd0;
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
      r_rd_data  <= 8'h00;
    end else begin
      r_rd_valid <= w_rd_fwd;
      r_rd_last  <= w_rd_fwd && ((r_rd_cnt + 9'd1) == w_rd_limit);
      if (w_rd_fwd) begin
        r_rd_data <= mydata_o;
        r_rd_cnt  <= r_rd_cnt + 9'd1;
      end
      if (w_accept) begin
        r_op       <= req_op_e'(req_op);
        r_addr     <= req_addr;
        r_wdata    <= req_wdata;
        r_rd_cnt   <= 9'd0;
        r_poll_cnt <= '0;
        r_err      <= 1'b0;
        r_wip      <= 1'b0;
      end
      if (r_state == StPollL) begin
        r_poll_cnt <= r_poll_cnt + PollW'(1);
        r_wip      <= 1'b0;
      end
      if ((r_state == StPollW) && myvalid_o) begin
        r_wip <= mydata_o[0];
      end
      if ((r_state == StPollW) && w_txn_done) begin
        r_err     <= w_wip_now & w_poll_max;
        r_gap_cnt <= GapW'(POLL_GAP - 1);
      end
      if ((r_state == StGap) && !w_gap_end) begin
        r_gap_cnt <= r_gap_cnt - GapW'(1);
      end
    end
  end

endmodule

// File: tb/tb_flash_op_sequencer.sv
// Directed bench for flash_op_sequencer with a behavioural spi engine model.
module tb_flash_op_sequencer;
  import flash_pkg::*;

  localparam int unsigned PollGap = 16;
  localparam int unsigned PollMax = 4;
  localparam int Lat     = 3;
  localparam int Timeout = 3000;

  logic        clock25M = 1'b0;
  logic        flash_rstn;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [23:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rd_valid;
  logic [7:0]  rd_data;
  logic        rd_last;
  logic        resp_done;
  logic        resp_err;
  logic [3:0]  cmd_type;
  logic [7:0]  flash_cmd;
  logic [23:0] flash_addr;
  logic [7:0]  wrdata;
  logic        Done_Sig;
  logic [7:0]  mydata_o;
  logic        myvalid_o;

  always #5 clock25M = ~clock25M;

  int cyc = 0;
  always @(posedge clock25M) cyc <= cyc + 1;

  flash_op_sequencer #(
    .POLL_GAP (PollGap),
    .POLL_MAX (PollMax)
  ) dut (
    .clock25M   (clock25M),
    .flash_rstn (flash_rstn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .rd_last    (rd_last),
    .resp_done  (resp_done),
    .resp_err   (resp_err),
    .cmd_type   (cmd_type),
    .flash_cmd  (flash_cmd),
    .flash_addr (flash_addr),
    .wrdata     (wrdata),
    .Done_Sig   (Done_Sig),
    .mydata_o   (mydata_o),
    .myvalid_o  (myvalid_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transaction log filled by the spi model
  logic [2:0]  tq_type[$];
  logic [7:0]  tq_cmd[$];
  logic [23:0] tq_addr[$];
  logic [7:0]  tq_data[$];
  int          tq_cyc[$];
  logic [7:0]  status_q[$];
  int          last_done_cyc = 0;

  // spi engine model: log each launch, return bytes Lat clocks later, then Done_Sig
  initial begin
    logic [2:0] ty;
    Done_Sig  = 1'b0;
    myvalid_o = 1'b0;
    mydata_o  = 8'h00;
    forever begin
      @(negedge clock25M);
      if (cmd_type[3] === 1'b1) begin
        ty = cmd_type[2:0];
        tq_type.push_back(ty);
        tq_cmd.push_back(flash_cmd);
        tq_addr.push_back(flash_addr);
        tq_data.push_back(wrdata);
        tq_cyc.push_back(cyc);
        repeat (Lat) @(negedge clock25M);
        if (ty == TxnRdid) begin
          myvalid_o = 1'b1; mydata_o = 8'hAA; @(negedge clock25M);
          mydata_o = 8'h55; @(negedge clock25M);
        end else if (ty == TxnRead) begin
          for (int i = 0; i < 256; i++) begin
            myvalid_o = 1'b1; mydata_o = 8'(i); @(negedge clock25M);
          end
        end else if (ty == TxnRdsr) begin
          myvalid_o = 1'b1;
          mydata_o  = (status_q.size() > 0) ? status_q.pop_front() : 8'h00;
          @(negedge clock25M);
        end
        myvalid_o     = 1'b0;
        Done_Sig      = 1'b1;
        last_done_cyc = cyc;
        @(negedge clock25M);
        Done_Sig = 1'b0;
      end
    end
  end

  // Output monitor: read stream, response pulses, launch width
  logic [7:0] rdq_data[$];
  logic       rdq_last[$];
  int         resp_cnt     = 0;
  int         multi_launch = 0;
  logic       prev_launch  = 1'b0;

  initial begin
    forever begin
      @(negedge clock25M);
      if (rd_valid === 1'b1) begin
        rdq_data.push_back(rd_data);
        rdq_last.push_back(rd_last);
      end
      if (resp_done === 1'b1) resp_cnt++;
      if ((cmd_type[3] === 1'b1) && prev_launch) multi_launch++;
      prev_launch = (cmd_type[3] === 1'b1);
    end
  end

  typedef struct {
    logic [1:0]       op;
    logic [23:0]      addr;
    logic [7:0]       wdata;
    int               nstat;
    logic [3:0][7:0]  stat;
    int               exp_txn;
    logic [2:0]       exp_type;
    logic [7:0]       exp_cmd;
    logic [23:0]      exp_addr;
    logic             exp_err;
    int               exp_rd;
  } vec_t;

  function automatic vec_t mk(logic [1:0] op, logic [23:0] addr, logic [7:0] wdata, int nstat,
                              logic [31:0] stat, int exp_txn, logic [2:0] exp_type,
                              logic [7:0] exp_cmd, logic [23:0] exp_addr, logic exp_err,
                              int exp_rd);
    vec_t v;
    v.op = op; v.addr = addr; v.wdata = wdata; v.nstat = nstat; v.stat = stat;
    v.exp_txn = exp_txn; v.exp_type = exp_type; v.exp_cmd = exp_cmd; v.exp_addr = exp_addr;
    v.exp_err = exp_err; v.exp_rd = exp_rd;
    return v;
  endfunction

  task automatic clear_logs();
    tq_type.delete(); tq_cmd.delete(); tq_addr.delete(); tq_data.delete(); tq_cyc.delete();
    rdq_data.delete(); rdq_last.delete(); status_q.delete();
  endtask

  vec_t vecs[6];

  initial begin
    int   accept_cyc, resp_c, busy_rdy, r0, mi, bad, n1, rc1;
    logic got, err, wr;
    logic [7:0] eb;

    // stat bytes are consumed from stat[0] upwards
    vecs[0] = mk(2'b00, 24'h123456, 8'h00, 0, 32'h0000_0000, 1, TxnRdid, 8'h90, 24'h000000, 1'b0, 2);
    vecs[1] = mk(2'b01, 24'h012000, 8'h00, 3, 32'h0000_0101, 5, TxnSe, 8'h20, 24'h012000, 1'b0, 0);
    vecs[2] = mk(2'b10, 24'h000010, 8'h5A, 4, 32'h0101_0101, 6, TxnPp, 8'h02, 24'h000010, 1'b1, 0);
    vecs[3] = mk(2'b11, 24'h000100, 8'h00, 0, 32'h0000_0000, 1, TxnRead, 8'h03, 24'h000100, 1'b0, 256);
    vecs[4] = mk(2'b01, 24'hABCDEF, 8'h00, 1, 32'h0000_0000, 3, TxnSe, 8'h20, 24'hABCDEF, 1'b0, 0);
    vecs[5] = mk(2'b10, 24'h7FFFFF, 8'hA5, 2, 32'h0000_0001, 4, TxnPp, 8'h02, 24'h7FFFFF, 1'b0, 0);

    flash_rstn = 1'b0;
    req_valid  = 1'b0;
    req_op     = 2'b00;
    req_addr   = 24'h0;
    req_wdata  = 8'h0;
    repeat (3) @(negedge clock25M);
    check("rst_req_ready", req_ready, 1);
    check("rst_cmd_type", cmd_type, 0);
    check("rst_resp_done", resp_done, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_flash_cmd", flash_cmd, 0);
    flash_rstn = 1'b1;

    for (int vi = 0; vi < 6; vi++) begin
      clear_logs();
      for (int j = 0; j < vecs[vi].nstat; j++) status_q.push_back(vecs[vi].stat[j]);
      wr = (vecs[vi].op == 2'b01) || (vecs[vi].op == 2'b10);
      r0 = resp_cnt;
      @(negedge clock25M);
      check("ready_idle", req_ready, 1);
      req_valid = 1'b1;
      req_op    = vecs[vi].op;
      req_addr  = vecs[vi].addr;
      req_wdata = vecs[vi].wdata;
      @(negedge clock25M);
      accept_cyc = cyc;
      req_valid  = 1'b0;
      req_addr   = ~vecs[vi].addr;
      req_wdata  = ~vecs[vi].wdata;
      got = 1'b0; err = 1'b0; resp_c = 0; busy_rdy = 0;
      for (int k = 0; k < Timeout; k++) begin
        if (resp_done === 1'b1) begin
          got = 1'b1; err = resp_err; resp_c = cyc;
          break;
        end
        if (req_ready === 1'b1) busy_rdy++;
        @(negedge clock25M);
      end
      check("done_seen", got, 1);
      check("resp_err", err, vecs[vi].exp_err);
      check("ready_busy", busy_rdy, 0);
      repeat (3) @(negedge clock25M);
      check("resp_pulses", resp_cnt - r0, 1);
      check("txn_count", tq_type.size(), vecs[vi].exp_txn);
      mi = wr ? 1 : 0;
      if (tq_type.size() > mi) begin
        check("main_type", tq_type[mi], vecs[vi].exp_type);
        check("main_cmd", tq_cmd[mi], vecs[vi].exp_cmd);
        check("main_addr", tq_addr[mi], vecs[vi].exp_addr);
        if (vecs[vi].op == 2'b10) check("main_wdata", tq_data[mi], vecs[vi].wdata);
      end
      if (tq_type.size() > 0) begin
        check("launch_lat", tq_cyc[0] - accept_cyc, 1);
        if (wr) begin
          check("wren_type", tq_type[0], TxnWren);
          check("wren_cmd", tq_cmd[0], 8'h06);
        end
      end
      if (wr) begin
        bad = 0;
        for (int i = mi + 1; i < tq_type.size(); i++) begin
          if (tq_type[i] !== TxnRdsr || tq_cmd[i] !== 8'h05) bad++;
          // status byte, Done_Sig, POLL_L and launch register add Lat+3 to the gap
          if (i > mi + 1 && (tq_cyc[i] - tq_cyc[i-1]) != int'(PollGap) + Lat + 3) bad++;
        end
        check("poll_seq", bad, 0);
      end
      check("resp_lat", resp_c - last_done_cyc, 1);
      check("rd_count", rdq_data.size(), vecs[vi].exp_rd);
      bad = 0;
      for (int i = 0; i < rdq_data.size(); i++) begin
        eb = (vecs[vi].op == 2'b00) ? ((i == 0) ? 8'hAA : 8'h55) : 8'(i);
        if (rdq_data[i] !== eb || rdq_last[i] !== (i == vecs[vi].exp_rd - 1)) bad++;
      end
      check("rd_stream", bad, 0);
    end

    // req_valid held high: the second op may only start after the first resp_done
    clear_logs();
    r0 = resp_cnt;
    @(negedge clock25M);
    req_valid = 1'b1;
    req_op    = 2'b00;
    req_addr  = 24'h000000;
    got = 1'b0; n1 = 0; rc1 = 0;
    for (int k = 0; k < Timeout; k++) begin
      @(negedge clock25M); #1;
      if (resp_done === 1'b1) begin
        got = 1'b1; n1 = tq_type.size(); rc1 = cyc;
        break;
      end
    end
    check("hold_first_done", got, 1);
    check("hold_txn_at_done", n1, 1);
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock25M); #1;
      if (tq_type.size() >= 2) begin
        got = 1'b1;
        break;
      end
    end
    req_valid = 1'b0;
    check("hold_second_launch", got, 1);
    if (tq_cyc.size() >= 2) check("hold_second_start", tq_cyc[1] - rc1, 3);
    got = 1'b0;
    for (int k = 0; k < Timeout; k++) begin
      @(negedge clock25M);
      if (resp_done === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    check("hold_second_done", got, 1);
    repeat (20) @(negedge clock25M);
    check("hold_resp_pulses", resp_cnt - r0, 2);
    check("hold_txn_total", tq_type.size(), 2);

    // Reset asserted while waiting for an RDSR to complete
    clear_logs();
    for (int j = 0; j < 8; j++) status_q.push_back(8'h01);
    @(negedge clock25M);
    req_valid = 1'b1;
    req_op    = 2'b01;
    req_addr  = 24'h020000;
    @(negedge clock25M);
    req_valid = 1'b0;
    got = 1'b0;
    for (int k = 0; k < Timeout; k++) begin
      @(negedge clock25M); #1;
      if (tq_type.size() >= 3) begin
        got = 1'b1;
        break;
      end
    end
    check("rst_reach_poll", got, 1);
    @(negedge clock25M);
    #2;
    r0 = resp_cnt;
    flash_rstn = 1'b0;
    #1;
    check("async_cmd_type", cmd_type, 0);
    check("async_req_ready", req_ready, 1);
    check("async_resp_done", resp_done, 0);
    repeat (3) @(negedge clock25M);
    flash_rstn = 1'b1;
    repeat (40) @(negedge clock25M);
    check("rst_no_resp", resp_cnt - r0, 0);
    check("rst_no_relaunch", tq_type.size(), 3);
    check("rst_idle_ready", req_ready, 1);

    check("launch_width", multi_launch, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
